// File: rtl/lock_input_pkg.sv
// Shared types and defaults for the combination-lock button front end.
package lock_input_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD0  = 2'd1,
    HELD1  = 2'd2,
    REJECT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer followed by a hold-time debouncer.
module debounce_channel
  import lock_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_out;
  logic [CNT_W-1:0] cnt;

  // A new level is accepted only after it has held for DEBOUNCE_CYCLES
  // consecutive synchronized cycles; any return to the old level restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
    end else begin
      sync_meta <= raw;
      sync_out  <= sync_meta;
      if (sync_out == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_out;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_pulse_encoder.sv
// Turns two bouncy button levels into single-cycle zero/one symbol pulses,
// rejecting simultaneous or overlapping presses with a conflict pulse.
module button_pulse_encoder
  import lock_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_zero,
  input  logic       raw_one,
  output logic       zero,
  output logic       one,
  output logic       conflict,
  output logic [1:0] state
);

  logic       db_zero;
  logic       db_one;
  logic       db_zero_q;
  logic       db_one_q;
  logic       zero_rise;
  logic       one_rise;
  arb_state_t arb;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_zero (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_zero),
    .level (db_zero)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_one (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw_one),
    .level (db_one)
  );

  assign zero_rise = db_zero & ~db_zero_q;
  assign one_rise  = db_one & ~db_one_q;
  assign state     = arb;

  // Arbitration: one pulse per accepted press; a second button while one is
  // held (or both at once) is flagged and locks out until both are released.
  always_ff @(posedge clk) begin
    if (rst) begin
      arb       <= IDLE;
      db_zero_q <= 1'b0;
      db_one_q  <= 1'b0;
      zero      <= 1'b0;
      one       <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      db_zero_q <= db_zero;
      db_one_q  <= db_one;
      zero      <= 1'b0;
      one       <= 1'b0;
      conflict  <= 1'b0;
      case (arb)
        IDLE: begin
          if (zero_rise && one_rise) begin
            conflict <= 1'b1;
            arb      <= REJECT;
          end else if (zero_rise) begin
            zero <= 1'b1;
            arb  <= HELD0;
          end else if (one_rise) begin
            one <= 1'b1;
            arb <= HELD1;
          end
        end
        HELD0: begin
          if (db_one) begin
            conflict <= 1'b1;
            arb      <= REJECT;
          end else if (!db_zero) begin
            arb <= IDLE;
          end
        end
        HELD1: begin
          if (db_zero) begin
            conflict <= 1'b1;
            arb      <= REJECT;
          end else if (!db_one) begin
            arb <= IDLE;
          end
        end
        REJECT: begin
          if (!db_zero && !db_one) begin
            arb <= IDLE;
          end
        end
        default: arb <= IDLE;
      endcase
    end
  end

endmodule
